// File: rtl/vga_pride_pkg.sv
// Shared constants, event codes and wrap helpers for the flag selection path.
package vga_pride_pkg;

    localparam int unsigned IDX_W_DEF = 7;
    // Working width for the wrap helpers; callers cast their index into it.
    localparam int unsigned IDX_MAX_W = 16;

    typedef enum logic [2:0] {
        EV_NONE = 3'd0,
        EV_ZERO = 3'd1,
        EV_NEXT = 3'd2,
        EV_PREV = 3'd3,
        EV_LOAD = 3'd4,
        EV_AUTO = 3'd5
    } ev_e;

    // Step forward, wrapping from max_v back to zero.
    function automatic logic [IDX_MAX_W-1:0] wrap_inc(input logic [IDX_MAX_W-1:0] cnt,
                                                      input logic [IDX_MAX_W-1:0] max_v);
        return (cnt == max_v) ? '0 : cnt + IDX_MAX_W'(1);
    endfunction

    // Step backward, wrapping from zero up to max_v.
    function automatic logic [IDX_MAX_W-1:0] wrap_dec(input logic [IDX_MAX_W-1:0] cnt,
                                                      input logic [IDX_MAX_W-1:0] max_v);
        return (cnt == '0) ? max_v : cnt - IDX_MAX_W'(1);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Multi-flop synchroniser for one async input, with a rising-edge pulse.
module btn_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_lvl,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Shift the pin through the chain and remember the last synced value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_lvl = chain[SYNC_STAGES-1];
    assign rise_c   = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/flag_select_ctrl.sv
// Flag index controller: synced buttons, auto-cycle, frame-aligned output.
module flag_select_ctrl
    import vga_pride_pkg::*;
#(
    parameter int unsigned IDX_W           = IDX_W_DEF,
    parameter int unsigned FRAMES_PER_STEP = 120,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_zero,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             btn_load,
    input  logic [IDX_W-1:0] load_val,
    input  logic             direct_mode,
    input  logic [IDX_W-1:0] direct_val,
    input  logic             auto_en,
    input  logic             frame_start,
    input  logic [IDX_W-1:0] max_idx,
    output logic [IDX_W-1:0] index,
    output logic             changed
);

    localparam int unsigned FCNT_W = $clog2(FRAMES_PER_STEP + 1);
    localparam int unsigned N_IN   = 6;

    // Bit order: zero, next, prev, load, direct_mode, auto_en.
    logic [N_IN-1:0] pins;
    logic [N_IN-1:0] lvl_s;
    logic [N_IN-1:0] rise_c;

    logic [IDX_W-1:0]  cnt;
    logic [IDX_W-1:0]  cnt_nxt;
    logic [FCNT_W-1:0] fcnt;
    logic [FCNT_W-1:0] fcnt_nxt;
    logic [IDX_W-1:0]  sel_c;
    logic              manual_c;
    logic              unused_ok;
    ev_e               ev_c;

    assign pins = {auto_en, direct_mode, btn_load, btn_prev, btn_next, btn_zero};

    // One synchroniser per async input.
    for (genvar i = 0; i < N_IN; i++) begin : g_sync
        btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .async_in (pins[i]),
            .sync_lvl (lvl_s[i]),
            .rise_c   (rise_c[i])
        );
    end

    // Buttons only need their edges, level inputs only their levels.
    assign unused_ok = &{1'b0, lvl_s[3:0], rise_c[5:4]};

    // Priority encoder: zero > next > prev > load > auto.
    always_comb begin
        ev_c = EV_NONE;
        if (rise_c[0])      ev_c = EV_ZERO;
        else if (rise_c[1]) ev_c = EV_NEXT;
        else if (rise_c[2]) ev_c = EV_PREV;
        else if (rise_c[3]) ev_c = EV_LOAD;
        else if (lvl_s[5] && frame_start && (fcnt == FCNT_W'(FRAMES_PER_STEP - 1)))
            ev_c = EV_AUTO;
    end

    assign manual_c = rise_c[0] | rise_c[1] | rise_c[2] | rise_c[3];

    // Next count; an out-of-range count is pulled back to zero before any event.
    always_comb begin
        cnt_nxt = cnt;
        if (cnt > max_idx) begin
            cnt_nxt = '0;
        end else begin
            case (ev_c)
                EV_ZERO:          cnt_nxt = '0;
                EV_NEXT, EV_AUTO: cnt_nxt = IDX_W'(wrap_inc(IDX_MAX_W'(cnt), IDX_MAX_W'(max_idx)));
                EV_PREV:          cnt_nxt = IDX_W'(wrap_dec(IDX_MAX_W'(cnt), IDX_MAX_W'(max_idx)));
                EV_LOAD:          cnt_nxt = (load_val > max_idx) ? '0 : load_val;
                default:          cnt_nxt = cnt;
            endcase
        end
    end

    // Frame counter: counts frames while auto is on, restarts on any manual event.
    always_comb begin
        fcnt_nxt = fcnt;
        if (manual_c || !lvl_s[5]) begin
            fcnt_nxt = '0;
        end else if (frame_start) begin
            fcnt_nxt = (fcnt == FCNT_W'(FRAMES_PER_STEP - 1)) ? '0 : fcnt + FCNT_W'(1);
        end
    end

    // Value offered to the renderer, clamped in direct mode.
    always_comb begin
        sel_c = cnt;
        if (lvl_s[4]) sel_c = (direct_val > max_idx) ? max_idx : direct_val;
    end

    // State update; index only moves on a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            fcnt    <= '0;
            index   <= '0;
            changed <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            fcnt <= fcnt_nxt;
            if (frame_start) begin
                index   <= sel_c;
                changed <= (sel_c != index);
            end else begin
                changed <= 1'b0;
            end
        end
    end

endmodule

// File: doc/flag_select_ctrl.md
Name: flag_select_ctrl

Overview:
Synchronous successor to the flag-index counter in the VGA pride display. It replaces the button-clocked counter with a single-clock controller. The controller synchronises and edge-detects the user buttons and adds an auto-cycle mode driven by frame pulses. It presents the selected flag index to the flag renderer only at frame boundaries, so a change never tears the picture. It sits between the top-level ui_in/uio_in pins and the flag_index lookup.

Parameters:
IDX_W, 7, width of flag index and of max_idx
FRAMES_PER_STEP, 120, frame_start pulses between automatic advances (must be >= 1)
SYNC_STAGES, 2, synchroniser depth for button and mode inputs (>= 2)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
btn_zero  in  1  async button: index <= 0
btn_next  in  1  async button: index + 1, wraps
btn_prev  in  1  async button: index - 1, wraps
btn_load  in  1  async button: index <= load_val
load_val  in  IDX_W  value for btn_load, sampled on the cycle the edge is detected
direct_mode  in  1  async level: display direct_val instead of the counter
direct_val  in  IDX_W  direct index, treated as quasi-static
auto_en  in  1  async level: enable automatic advance
frame_start  in  1  one-cycle pulse at the first pixel of each frame, from the hvsync generator
max_idx  in  IDX_W  highest valid flag index, from flag_index
index  out  IDX_W  frame-stable index to the renderer
changed  out  1  one-cycle pulse when index updates to a different value

Behaviour:
- Reset: clk and rst_n only; reset is asynchronous and active-low. All synchroniser flops, edge-detect history, counter, frame counter, index and changed clear to 0.
- Synchronisation: btn_*, direct_mode and auto_en each pass through SYNC_STAGES flops.
- Edge detection: a rising edge is sync_out=1 with the previous value 0, giving one event per press. Latency from pin to event is SYNC_STAGES+1 cycles.
- Event priority within one cycle: zero > next > prev > load > auto. Only the highest-priority event acts.
- Counter (IDX_W bits):
  - next: cnt == max_idx ? 0 : cnt+1.
  - prev: cnt == 0 ? max_idx : cnt-1.
  - load: load_val > max_idx ? 0 : load_val.
  - zero: 0.
- Any manual event clears the frame counter.
- Auto mode:
  - When auto_en (synchronised) is 1, the frame counter increments on each frame_start.
  - On the frame_start that makes it equal FRAMES_PER_STEP, the counter advances as for next and the frame counter returns to 0.
  - A manual event in the same cycle wins, and the frame counter clears.
  - When auto_en is 0, the frame counter holds at 0.
- Range guard: if cnt > max_idx (max_idx has shrunk), cnt is forced to 0 on the next cycle, ahead of any event.
- Output staging:
  - The selected value is sel = direct_mode ? min(direct_val, max_idx) : cnt.
  - index loads sel only in a cycle where frame_start=1. Between frame pulses it holds.
  - The counter update and the index load in the same frame_start cycle use the pre-update cnt. The new count is shown at the next frame_start.
  - changed=1 for exactly the cycle after index loads a value different from its previous value.
- Reset mid-frame forces index to 0 at once; the next frame_start shows sel.
- Frame counter width is clog2(FRAMES_PER_STEP+1). With FRAMES_PER_STEP=1, auto advances every frame.

Decomposition:
- Shared package vga_pride_pkg holds:
  - an IDX_W default constant;
  - an event-code enum (EV_NONE, EV_ZERO, EV_NEXT, EV_PREV, EV_LOAD, EV_AUTO) used by the priority encoder and bench scoreboard;
  - a function wrap_inc/wrap_dec(cnt, max).
- One sub-module: btn_sync_edge (parametrised SYNC_STAGES; outputs sync level and rise pulse), instantiated per button and for each level input.

Test Plan:
1. Reset, max_idx=5. Press btn_next 7 times, with frame_start every 100 cycles -> cnt sequence 1,2,3,4,5,0,1. Index follows only at frame_start, and changed pulses at each different value.
2. cnt=0, one btn_prev press -> cnt=5. btn_prev held high for 50 cycles -> exactly one decrement. Event appears SYNC_STAGES+1 cycles after the pin edge.
3. auto_en=1, FRAMES_PER_STEP=3, max_idx=2 -> index 0,0,0,0,1,1,1,2... (the advance lags one frame due to staging). A btn_next mid-count restarts the 3-frame count.
4. btn_zero and btn_next rise in the same cycle with cnt=3 -> cnt=0. btn_load with load_val=9 and max_idx=5 -> cnt=0; load_val=4 -> cnt=4.
5. direct_mode=1, direct_val=20, max_idx=12 -> index=12 at the next frame_start. direct_mode=0 -> index returns to cnt at the following frame_start.
6. cnt=10, then max_idx drops to 6 -> cnt=0 next cycle. Assert rst_n low mid-frame -> index=0 and changed=0 immediately, asynchronously.
